// File: rtl/trp_stream_pkg.sv
// Shared mode encodings and FSM state type for the trp_stream_unit slice.
package trp_stream_pkg;

  localparam logic [1:0] MODE_SUM = 2'b00;
  localparam logic [1:0] MODE_MAX = 2'b01;
  localparam logic [1:0] MODE_MIN = 2'b10;
  localparam logic [1:0] MODE_TRP = 2'b11;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD       = 2'd1,
    REDUCE_OUT = 2'd2,
    DRAIN      = 2'd3
  } state_t;

endpackage

// File: rtl/trp_reduce_alu.sv
// Next-accumulator logic for the reduction modes: wrapping sum, signed max, signed min.
module trp_reduce_alu
  import trp_stream_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] elem_i,
  input  logic [1:0]       mode_i,
  input  logic             first_i,
  output logic [WIDTH-1:0] acc_o
);

  always_comb begin
    acc_o = acc_i;
    if (first_i) begin
      acc_o = elem_i;
    end else begin
      case (mode_i)
        MODE_SUM: acc_o = acc_i + elem_i;
        MODE_MAX: acc_o = ($signed(elem_i) > $signed(acc_i)) ? elem_i : acc_i;
        MODE_MIN: acc_o = ($signed(elem_i) < $signed(acc_i)) ? elem_i : acc_i;
        default:  acc_o = acc_i;
      endcase
    end
  end

endmodule

// File: rtl/trp_stream_unit.sv
// Streaming reduce (sum/max/min) and DEPTHxDEPTH transpose unit.
// Optional abort input `flush` exists only when TRP_STREAM_FLUSH_EN is defined.
//
// state      | meaning
// IDLE       | waiting for first element; mode is latched on its transfer
// LOAD       | accepting remaining elements into accumulator or buffer
// REDUCE_OUT | presenting reduction result until consumed
// DRAIN      | emitting buffered matrix in column-major order
module trp_stream_unit
  import trp_stream_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
`ifdef TRP_STREAM_FLUSH_EN
  input  logic             flush,
`endif
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int LG  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH * DEPTH);
  localparam int NEL = DEPTH * DEPTH;

  state_t           state_q;
  logic [1:0]       mode_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] buf_q [NEL];

  logic       abort;
  logic       in_fire;
  logic       out_fire;
  logic       last_in;
  logic [1:0] op_mode;
  logic [CW-1:0] rd_addr;

`ifdef TRP_STREAM_FLUSH_EN
  assign abort = reset | flush;
`else
  assign abort = reset;
`endif

  assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
  assign out_valid = (state_q == REDUCE_OUT) || (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_ready & out_valid;
  assign op_mode   = (state_q == IDLE) ? mode : mode_q;
  assign last_in   = (mode_q == MODE_TRP) ? (cnt_q == CW'(NEL - 1)) : (cnt_q == CW'(DEPTH - 1));

  // Drain count is col*DEPTH+row; swapping its halves gives the row-major buffer address.
  assign rd_addr = {cnt_q[LG-1:0], cnt_q[CW-1:LG]};

  always_comb begin
    out_data = '0;
    if (state_q == REDUCE_OUT) out_data = acc_q;
    else if (state_q == DRAIN) out_data = buf_q[rd_addr];
  end

  trp_reduce_alu #(.WIDTH(WIDTH)) u_alu (
    .acc_i  (acc_q),
    .elem_i (in_data),
    .mode_i (op_mode),
    .first_i(state_q == IDLE),
    .acc_o  (acc_d)
  );

  always_ff @(posedge clk) begin
    if (abort) begin
      state_q <= IDLE;
      mode_q  <= MODE_SUM;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            mode_q  <= mode;
            acc_q   <= acc_d;
            cnt_q   <= CW'(1);
            state_q <= LOAD;
          end
        end
        LOAD: begin
          if (in_fire) begin
            acc_q <= acc_d;
            if (last_in) begin
              cnt_q   <= '0;
              state_q <= (mode_q == MODE_TRP) ? DRAIN : REDUCE_OUT;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        REDUCE_OUT: begin
          if (out_fire) state_q <= IDLE;
        end
        DRAIN: begin
          if (out_fire) begin
            if (cnt_q == CW'(NEL - 1)) begin
              cnt_q   <= '0;
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Buffer is deliberately not reset; DRAIN is only reachable after a full load.
  always_ff @(posedge clk) begin
    if (in_fire && !abort && (op_mode == MODE_TRP)) buf_q[cnt_q] <= in_data;
  end

endmodule
